// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding and price-table helper for the vending controller
package vend_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 3'd0,
        ACCEPT   = 3'd1,
        CHECK    = 3'd2,
        DISPENSE = 3'd3,
        CHANGE   = 3'd4
    } state_t;

    // Bit offset of an item's price inside the flattened price table.
    function automatic int price_lsb(input int item, input int credit_w);
        return item * credit_w;
    endfunction

endpackage

// File: rtl/vend_txn_ctrl_if.sv
// rtl/vend_txn_ctrl_if.sv - front-end/back-end signal bundle of the vending transaction controller
interface vend_txn_ctrl_if #(
    parameter int CREDIT_W  = 8,
    parameter int NUM_ITEMS = 4
);
    localparam int ITEM_W = $clog2(NUM_ITEMS);

    logic                          coin_valid;
    logic [CREDIT_W-1:0]           coin_value;
    logic                          sel_valid;
    logic [ITEM_W-1:0]             sel_item;
    logic                          cancel;
    logic [NUM_ITEMS*CREDIT_W-1:0] price_tbl;
    logic                          dispense_done;
    logic                          change_ready;
    logic [2:0]                    state;
    logic [CREDIT_W-1:0]           credit;
    logic                          dispense_req;
    logic [ITEM_W-1:0]             dispense_item;
    logic                          change_valid;
    logic [CREDIT_W-1:0]           change_amt;
    logic                          insufficient;
    logic                          coin_reject;
    logic                          overflow;

    modport slave (
        input  coin_valid, coin_value, sel_valid, sel_item, cancel, price_tbl,
               dispense_done, change_ready,
        output state, credit, dispense_req, dispense_item, change_valid, change_amt,
               insufficient, coin_reject, overflow
    );

    modport master (
        output coin_valid, coin_value, sel_valid, sel_item, cancel, price_tbl,
               dispense_done, change_ready,
        input  state, credit, dispense_req, dispense_item, change_valid, change_amt,
               insufficient, coin_reject, overflow
    );

endinterface

// File: rtl/vend_credit_acc.sv
// rtl/vend_credit_acc.sv - saturating credit accumulator with sticky overflow flag
module vend_credit_acc #(
    parameter int CREDIT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    input  logic                load_i,
    input  logic                add_i,
    input  logic                sub_i,
    input  logic                ovf_clr_i,
    input  logic [CREDIT_W-1:0] val_i,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                overflow_o
);

    logic [CREDIT_W-1:0] credit_q;
    logic                ovf_q;
    logic [CREDIT_W:0]   sum;

    assign sum = {1'b0, credit_q} + {1'b0, val_i};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (clr_i) begin
                credit_q <= '0;
            end else if (load_i) begin
                credit_q <= val_i;
            end else if (add_i) begin
                if (sum[CREDIT_W]) begin
                    credit_q <= '1;
                    ovf_q    <= 1'b1;
                end else begin
                    credit_q <= sum[CREDIT_W-1:0];
                end
            end else if (sub_i) begin
                credit_q <= credit_q - val_i;
            end
            if (ovf_clr_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign credit_o   = credit_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/vend_txn_ctrl.sv
// rtl/vend_txn_ctrl.sv - vending transaction FSM: accept coins, check price, dispense, return change
// Optional ACCEPT-state inactivity refund enabled by defining VEND_TIMEOUT_EN.
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int CREDIT_W    = 8,
    parameter int NUM_ITEMS   = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input logic            clk,
    input logic            rst_n,
    vend_txn_ctrl_if.slave bus
);

    localparam int ITEM_W = $clog2(NUM_ITEMS);

    state_t              state_q, state_d;
    logic [ITEM_W-1:0]   item_q;
    logic                disp_req_q, chg_valid_q, insuff_q, coin_rej_q;
    logic [CREDIT_W-1:0] credit, price, acc_val;
    logic                overflow, acc_clr, acc_load, acc_add, acc_sub, ovf_clr;
    logic                chk_ok, quiet, tmo_hit;

    assign price  = bus.price_tbl[price_lsb(int'(item_q), CREDIT_W) +: CREDIT_W];
    assign chk_ok = (credit >= price);
    assign quiet  = !bus.coin_valid && !bus.sel_valid;

`ifdef VEND_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q;

    // Counts consecutive quiet ACCEPT cycles; any coin/selection restarts the window.
    always_ff @(posedge clk) begin
        if (!rst_n || state_q != ACCEPT || !quiet) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q == ACCEPT) && quiet && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        acc_clr  = 1'b0;
        acc_load = 1'b0;
        acc_add  = 1'b0;
        acc_sub  = 1'b0;
        acc_val  = bus.coin_value;
        case (state_q)
            IDLE: begin
                if (bus.coin_valid) begin
                    acc_load = 1'b1;
                    state_d  = ACCEPT;
                end
            end
            ACCEPT: begin
                acc_add = bus.coin_valid;
                if (bus.cancel || tmo_hit) begin
                    state_d = CHANGE;
                end else if (bus.sel_valid) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (chk_ok) begin
                    acc_sub = 1'b1;
                    acc_val = price;
                    state_d = DISPENSE;
                end else begin
                    state_d = ACCEPT;
                end
            end
            DISPENSE: begin
                if (bus.dispense_done) begin
                    state_d = (credit != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                if (chg_valid_q && bus.change_ready) begin
                    acc_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                acc_clr = 1'b1;
                state_d = IDLE;
            end
        endcase
        ovf_clr = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            item_q      <= '0;
            disp_req_q  <= 1'b0;
            chg_valid_q <= 1'b0;
            insuff_q    <= 1'b0;
            coin_rej_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ACCEPT && bus.sel_valid && !bus.cancel && !tmo_hit) begin
                item_q <= bus.sel_item;
            end
            disp_req_q  <= (state_d == DISPENSE);
            chg_valid_q <= (state_d == CHANGE);
            insuff_q    <= (state_q == CHECK) && !chk_ok;
            coin_rej_q  <= bus.coin_valid && (state_q != IDLE) && (state_q != ACCEPT);
        end
    end

    vend_credit_acc #(.CREDIT_W(CREDIT_W)) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (acc_clr),
        .load_i    (acc_load),
        .add_i     (acc_add),
        .sub_i     (acc_sub),
        .ovf_clr_i (ovf_clr),
        .val_i     (acc_val),
        .credit_o  (credit),
        .overflow_o(overflow)
    );

    assign bus.state         = state_q;
    assign bus.credit        = credit;
    assign bus.dispense_req  = disp_req_q;
    assign bus.dispense_item = item_q;
    assign bus.change_valid  = chg_valid_q;
    assign bus.change_amt    = chg_valid_q ? credit : '0;
    assign bus.insufficient  = insuff_q;
    assign bus.coin_reject   = coin_rej_q;
    assign bus.overflow      = overflow;

endmodule
